// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions used by the instruction-memory loader.
// Provides the memory address width, instruction byte count, loader
// FSM states and a length clamp helper.
package rv32i_pkg;

  localparam int DPW           = 7;
  localparam int BytesPerInstr = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } loader_state_e;

  // Limit a requested instruction count to what fits in instruction memory.
  function automatic logic [DPW-1:0] clamp_instr(input logic [DPW-1:0] len,
                                                 input logic [DPW-1:0] max_instr);
    return (len > max_instr) ? max_instr : len;
  endfunction

endpackage

// File: rtl/imem_loader_cksum.sv
// Running modulo-256 sum of accepted program bytes for the loader.
// Only instantiated when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_cksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  // Clear has priority so a new load never inherits a stale sum.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader that writes a program into instruction memory from
// address 0 and stalls fetch while loading.
// Optional checksum byte after the program: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int ElemWidth = 8,
  parameter int Depth     = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [DPW-1:0]       len_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 mem_we_o,
  output logic [DPW-1:0]       mem_addr_o,
  output logic [ElemWidth-1:0] mem_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [DPW-1:0]       word_cnt_o
);

  localparam logic [DPW-1:0] MaxInstr = DPW'(Depth / BytesPerInstr);

  loader_state_e        state_q, state_d;
  logic [DPW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DPW-1:0]       tot_q, tot_d;
  logic [DPW-1:0]       word_cnt_q, word_cnt_d;
  logic                 we_q, we_d;
  logic [DPW-1:0]       addr_q, addr_d;
  logic [ElemWidth-1:0] wdata_q, wdata_d;
  logic [DPW-1:0]       n_instr;
  logic                 ready;
  logic                 hs;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       err_q, err_d;
  logic       cks_clr;
  logic       cks_add;
  logic [7:0] cks_sum;

  imem_loader_cksum u_cksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cks_clr),
    .add_i  (cks_add),
    .data_i (byte_data_i),
    .sum_o  (cks_sum)
  );
`endif

  assign n_instr = clamp_instr(len_i, MaxInstr);
  assign hs      = byte_valid_i & ready;

  // Next-state, datapath updates and state-decoded outputs.
  // DONE shares the start decision with IDLE so a restart needs no extra cycle.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tot_d      = tot_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready      = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d   = err_q;
    cks_clr = 1'b0;
    cks_add = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        done_o = (state_q == DONE);
        if (start_i) begin
          byte_cnt_d = '0;
          word_cnt_d = '0;
          tot_d      = {n_instr[DPW-3:0], 2'b00};
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          cks_clr = 1'b1;
          state_d = (n_instr == '0) ? CHECK : LOAD;
`else
          state_d = (n_instr == '0) ? DONE : LOAD;
`endif
        end
      end
      LOAD: begin
        busy_o = 1'b1;
        ready  = 1'b1;
        if (hs) begin
          we_d       = 1'b1;
          addr_d     = byte_cnt_q;
          wdata_d    = ElemWidth'(byte_data_i);
          byte_cnt_d = byte_cnt_q + DPW'(1);
          if (byte_cnt_q[1:0] == 2'b11) begin
            word_cnt_d = word_cnt_q + DPW'(1);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          cks_add = 1'b1;
          if (byte_cnt_q == tot_q - DPW'(1)) state_d = CHECK;
`else
          if (byte_cnt_q == tot_q - DPW'(1)) state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        busy_o = 1'b1;
        ready  = 1'b1;
        if (hs) begin
          err_d   = (byte_data_i != cks_sum);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      tot_q      <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tot_q      <= tot_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Sticky checksum error flag, cleared on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign byte_ready_o = ready;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. Expected writes come from
// a byte-list model: byte k of the stream lands at address k one cycle after
// it is accepted, instructions complete every 4 bytes, and the program length
// is min(len, 30).
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [6:0] len_i = '0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_data_i = '0;
  logic       byte_ready_o;
  logic       mem_we_o;
  logic [6:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [6:0] word_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] stim [0:119];

  imem_loader #(.ElemWidth(8), .Depth(120)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we"}, 32'(mem_we_o), 0);
    check_eq({tag, "_addr"}, 32'(mem_addr_o), 0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata_o), 0);
    check_eq({tag, "_ready"}, 32'(byte_ready_o), 0);
    check_eq({tag, "_busy"}, 32'(busy_o), 0);
    check_eq({tag, "_done"}, 32'(done_o), 0);
    check_eq({tag, "_err"}, 32'(err_o), 0);
    check_eq({tag, "_wcnt"}, 32'(word_cnt_o), 0);
  endtask

  // One load: pct<0 toggles valid every other cycle, otherwise valid with
  // probability pct%. abort_after>=0 pulses reset once that many bytes went in.
  task automatic run_load(input int len, input int pct, input int abort_after,
                          input logic [7:0] cks_delta);
    int n, nb, k, pk;
    bit pend, cks_done, valid, finished;
    logic [7:0] pd, sum;
    n = (len > 30) ? 30 : len;
    nb = 4 * n;
    k = 0; pk = 0; pend = 0; pd = '0; sum = '0;
    cks_done = !CKS;
    finished = 0;
    @(negedge clk);
    start_i = 1'b1;
    len_i = 7'(len);
    byte_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    if (CKS || n > 0) check_eq("busy_after_start", 32'(busy_o), 1);
    else check_eq("done_len0", 32'(done_o), 1);
    check_eq("wcnt_after_start", 32'(word_cnt_o), 0);
    check_eq("err_after_start", 32'(err_o), 0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend) begin
        check_eq("we", 32'(mem_we_o), 1);
        check_eq("addr", 32'(mem_addr_o), 32'(pk));
        check_eq("wdata", 32'(mem_wdata_o), 32'(pd));
        check_eq("wcnt", 32'(word_cnt_o), 32'((pk + 1) / 4));
        pend = 0;
      end else begin
        check_eq("no_write", 32'(mem_we_o), 0);
      end
      if (abort_after >= 0 && k == abort_after) begin
        byte_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == nb && cks_done) begin
        finished = 1;
        break;
      end
      check_eq("ready_in_load", 32'(byte_ready_o), 1);
      valid = (pct < 0) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < pct);
      byte_valid_i = valid;
      if (!valid) byte_data_i = 8'($urandom);
      else if (k < nb) byte_data_i = stim[k];
      else byte_data_i = sum + cks_delta;
      if (valid && byte_ready_o) begin
        if (k < nb) begin
          pend = 1; pk = k; pd = stim[k];
          sum = sum + stim[k];
          k++;
        end else begin
          cks_done = 1;
        end
      end
    end
    byte_valid_i = 1'b0;
    if (!finished) check_eq("load_timeout", 0, 1);
    check_eq("ready_end", 32'(byte_ready_o), 0);
    check_eq("done_end", 32'(done_o), 1);
    check_eq("busy_end", 32'(busy_o), 0);
    check_eq("wcnt_end", 32'(word_cnt_o), 32'(n));
    check_eq("err_end", 32'(err_o), 32'(CKS && cks_delta != 8'h00));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 120; i++) stim[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] prog8 [0:7];
    logic [7:0] prog4 [0:3];
    prog8 = '{8'h03, 8'h22, 8'h02, 8'h00, 8'h83, 8'hA2, 8'h42, 8'h00};
    prog4 = '{8'h23, 8'h24, 8'h60, 8'h00};

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle ignores offered bytes.
    byte_valid_i = 1'b1;
    byte_data_i = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("idle");
    end
    byte_valid_i = 1'b0;

    // Two-instruction program, back-to-back bytes.
    fill_random();
    for (int i = 0; i < 8; i++) stim[i] = prog8[i];
    run_load(2, 100, -1, 8'h00);

    // DONE does not consume bytes.
    byte_valid_i = 1'b1;
    byte_data_i = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("done_no_write", 32'(mem_we_o), 0);
      check_eq("done_no_ready", 32'(byte_ready_o), 0);
      check_eq("done_hold", 32'(done_o), 1);
      check_eq("done_wcnt_hold", 32'(word_cnt_o), 2);
    end
    byte_valid_i = 1'b0;

    // One instruction, valid toggling.
    fill_random();
    run_load(1, -1, -1, 8'h00);

    // Length above capacity is clamped to 30 instructions.
    fill_random();
    run_load(40, 100, -1, 8'h00);

    // Reset after 5 bytes of a 2-instruction load, then a fresh load.
    fill_random();
    run_load(2, 100, 5, 8'h00);
    fill_random();
    run_load(1, 100, -1, 8'h00);

    // Empty program.
    run_load(0, 100, -1, 8'h00);

    // Checksum good (0xA7) then bad (0xA6).
    for (int i = 0; i < 4; i++) stim[i] = prog4[i];
    run_load(1, 100, -1, 8'h00);
    run_load(1, 100, -1, 8'hFF);

    // Random lengths and stall patterns.
    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_load(int'($urandom_range(0, 40)), int'($urandom_range(40, 100)), -1,
               (t % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the byte-addressed instruction memory read by the fetch stage (PCF -> 32-bit little-endian instr).
- Accepts a byte stream over a valid/ready handshake and emits registered byte writes that place a program at instruction-memory address 0.
- Counts complete instructions and holds the core fetch stage (busy_o) until loading finishes.
- Sits between a boot/debug byte source and the instruction-memory write port.

Parameters:
ElemWidth, 8, bits per memory element; must be 8.
Depth, 120, memory elements. MaxInstr = Depth/4 = 30.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  pulse; begin a load of len_i instructions.
len_i  input  DPW  instruction count, sampled on the accepted start_i.
byte_valid_i  input  1  stream byte valid.
byte_data_i  input  8  stream byte.
byte_ready_o  output  1  loader accepts a byte this cycle.
mem_we_o  output  1  memory byte write enable.
mem_addr_o  output  DPW  memory byte address.
mem_wdata_o  output  ElemWidth  memory byte data.
busy_o  output  1  load in progress; fetch must stall.
done_o  output  1  load complete; level signal.
err_o  output  1  checksum error; always 0 without the feature.
word_cnt_o  output  DPW  complete instructions written.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0; FSM goes to IDLE; byte and word counters cleared.
  - Memory contents are not touched.
  - Reset mid-load aborts the load immediately. Partial bytes remain in memory; word_cnt_o returns to 0.
- FSM states: IDLE, LOAD, CHECK (present only with the feature), DONE.
- IDLE:
  - byte_ready_o=0.
  - start_i=1: latch N = min(len_i, MaxInstr).
    - N=0: go to DONE directly.
    - Otherwise go to LOAD with the byte counter at 0.
- LOAD:
  - busy_o=1, byte_ready_o=1.
  - On handshake (byte_valid_i & byte_ready_o) at cycle t, the write appears at cycle t+1:
    - mem_we_o=1, mem_addr_o=byte counter value at t, mem_wdata_o=byte_data_i at t.
  - mem_we_o is otherwise 0. mem_addr_o and mem_wdata_o hold their last values.
  - Byte k of the stream goes to address k. Little-endian: stream order 03 22 02 00 yields instr 0x00022203 at PC 0.
  - word_cnt_o increments in the same cycle as the write of each 4th byte (k mod 4 = 3).
  - Handshake on byte 4N-1: byte_ready_o drops the next cycle. Go to CHECK (feature) or DONE.
  - start_i is ignored while in LOAD.
- DONE:
  - busy_o=0, done_o=1, byte_ready_o=0. Bytes offered are not consumed.
  - start_i=1 clears done_o, err_o, word_cnt_o and the counters, then re-enters the IDLE decision for the new len_i. This takes effect the next cycle.
- Write address range: never exceeds 4*MaxInstr-1; guaranteed by the clamp.
- byte_valid_i low in LOAD stalls with no side effects. A valid byte held across cycles is consumed once per ready cycle.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit modulo-256 sum of all accepted program bytes is kept.
  - After the last program byte, the FSM enters CHECK with byte_ready_o=1 and accepts exactly one checksum byte, which is not written to memory.
  - If the checksum byte differs from the sum, err_o=1 in DONE. err_o stays set until the next start_i or reset.
  - N=0 still passes through CHECK; the expected value is 0.
- Undefined:
  - No CHECK state and no sum register; err_o is tied to 0.

Decomposition:
- rv32i_pkg gains:
  - typedef enum loader_state_e {IDLE, LOAD, CHECK, DONE};
  - localparam BytesPerInstr = 4.
- DPW is reused from the package.
- Single module. The checksum accumulator may be split into sub-module imem_loader_cksum, instantiated only under the macro.

Test Plan:
- Reset then idle: all outputs 0; byte_valid_i=1 with data 0xAA -> no write, byte_ready_o=0.
- start_i, len_i=2, stream 03 22 02 00 83 A2 42 00 back-to-back:
  - Writes go to addr 0..7 with matching data, each one cycle after its handshake.
  - word_cnt_o reads 1 then 2.
  - done_o=1 and busy_o=0 after the last write.
- len_i=1 with byte_valid_i toggling every other cycle: exactly 4 writes to addr 0..3, no duplicates; done_o=1.
- len_i=40 -> clamp to 30: 120 writes to addr 0..119; word_cnt_o=30; no address above 119.
- rst_n pulsed low after 5 bytes of a len_i=2 load:
  - Outputs clear asynchronously; state is IDLE.
  - A fresh start_i, len_i=1 writes to addr 0..3.
- With IMEM_LOADER_CHECKSUM_EN, len_i=1, bytes 23 24 60 00:
  - Checksum 0xA7 -> err_o=0.
  - Checksum 0xA6 -> err_o=1.
  - In both cases exactly 4 memory writes.
